fifo_drain_pack: RTL and testbench
==================================

# fifo_drain_pack

Single-clock consumer on the read side of the async FIFO. Drains a programmed number of WIDTH-bit entries by pulsing `fifo_rinc`, absorbs the FIFO's fixed read latency in a credit-limited skid buffer, and packs PACK consecutive entries into one wide word. Words go downstream over a valid/ready handshake, with a last-word flag and a completion pulse.

## Interface
- `WIDTH`, 8: FIFO entry width.
- `PACK`, 4: entries per output word (≥2).
- `RD_LAT`, 2: cycles from a `fifo_rinc`=1 cycle to valid `fifo_rdata`.
- `SKID_DEPTH`, 4: skid buffer entries (≥ RD_LAT+2 for full throughput).
- `clk`  in  1  read-domain clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to begin a drain; honoured only in IDLE.
- `cfg_words`  in  16  output words to produce; sampled on accepted `start`.
- `fifo_rempty`  in  1  FIFO empty flag.
- `fifo_rinc`  out  1  FIFO pop request.
- `fifo_rdata`  in  WIDTH  FIFO read data.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  downstream accepts when high together with `out_valid`.
- `out_data`  out  WIDTH*PACK  packed word.
- `out_last`  out  1  qualifies the final word of the drain.
- `busy`  out  1  high in DRAIN and FLUSH.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE → DRAIN on `start`. DRAIN → FLUSH once all cfg_words*PACK pops are issued. FLUSH → DONE when the last word handshakes. DONE → IDLE after one cycle (`done`=1 only in DONE).
- `start` with `cfg_words`=0: IDLE → DONE; no pop is issued.
- `start` outside IDLE is ignored.
- Pop issue: `fifo_rinc` = DRAIN & !`fifo_rempty` & (issued < cfg_words*PACK) & (outstanding + skid_count < SKID_DEPTH). Combinational from registered state and `fifo_rempty`.
- Outstanding tracker: RD_LAT-deep shift register of issue bits. The bit leaving the tail writes `fifo_rdata` into the skid tail.
- Issued counter and word counter are 16+$clog2(PACK) bits wide and compared exactly. Nothing wraps within one drain.
- Skid buffer: circular, SKID_DEPTH entries. Credit rule guarantees no overflow. Simultaneous push and pop keep the count unchanged.
- Packer: pops the skid head into lane `idx` when the lane register is free, then `idx` increments modulo PACK. When the PACK-th lane is popped in a cycle where the output register is empty or being accepted, the full word loads into `out_data` on that edge. Otherwise the packer stalls and the skid fills, which throttles `fifo_rinc` through the credit rule.
- `out_last` is high with the word whose index is cfg_words-1.
- Reset mid-operation clears all state. Entries already popped or in flight are discarded; the FIFO is not rewound.
- Reset values: `fifo_rinc`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0, state=IDLE, all counters and pointers 0.

## Timing
- `start` accepted in cycle s → first `fifo_rinc` possible in s+1.
- Entry k popped in cycle t → in skid from t+RD_LAT+1 → in a lane from t+RD_LAT+2.
- FIFO never empty and `out_ready`=1: first `out_valid` in cycle s+PACK+RD_LAT+2, then one word every PACK cycles.
- `out_valid`, `out_data` and `out_last` hold stable until the handshake.
- Last handshake in cycle h → `done`=1 in h+1, `busy`=0 from h+1.

## Configuration
- `FIFO_DRAIN_MSB_FIRST_EN` defined: the first entry of each word lands in the most significant lane (`out_data[WIDTH*PACK-1 -: WIDTH]`).
- Undefined: the first entry lands in lane 0 (`out_data[WIDTH-1:0]`).
- No other behaviour changes.

## Test plan
- Default params, FIFO preloaded 0x01..0x08, cfg_words=2, `out_ready`=1 → words 0x04030201 then 0x08070605, `out_last` only on the second, `done` one cycle after; first `out_valid` at s+8.
- Same with `FIFO_DRAIN_MSB_FIRST_EN` → 0x01020304, 0x05060708.
- `out_ready` held low 20 cycles mid-drain → at most SKID_DEPTH entries popped beyond the packer, no data loss or duplication; sequence resumes intact.
- `fifo_rempty` toggled randomly, cfg_words=16 → exactly 64 pops, 16 words in order, `fifo_rinc` never high while `fifo_rempty`=1.
- cfg_words=0 → `done` at s+1, `fifo_rinc` never asserted; `start` pulsed while `busy` → ignored.
- `rst` asserted mid-DRAIN → next cycle all outputs at reset values; a new `start` drains from the current FIFO head.

Source files
------------

// File: rtl/fifo_drain_pack_if.sv
// fifo_drain_pack_if: FIFO read side plus packed valid/ready output of fifo_drain_pack
// master: drain engine (drives fifo_rinc, out_valid, out_data, out_last)
// slave:  FIFO and downstream (drive fifo_rempty, fifo_rdata, out_ready)
interface fifo_drain_pack_if #(
  parameter int WIDTH = 8,
  parameter int PACK = 4
);
  logic fifo_rempty;
  logic fifo_rinc;
  logic [WIDTH-1:0] fifo_rdata;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic [WIDTH*PACK-1:0] out_data;
  modport master (
    input fifo_rempty, fifo_rdata, out_ready,
    output fifo_rinc, out_valid, out_data, out_last
  );
  modport slave (
    output fifo_rempty, fifo_rdata, out_ready,
    input fifo_rinc, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fifo_drain_pack.sv
// fifo_drain_pack: drains cfg_words*PACK FIFO entries through a credit-limited skid buffer, packing PACK entries per word
// Ports: clk, rst (sync, active-high); start/cfg_words drain request; busy/done status;
//        bus (fifo_drain_pack_if.master) FIFO pop side and packed valid/ready output.
// Macro FIFO_DRAIN_MSB_FIRST_EN: first entry of each word in the most significant lane (default lane 0).
module fifo_drain_pack #(
  parameter int WIDTH = 8,
  parameter int PACK = 4,
  parameter int RD_LAT = 2,
  parameter int SKID_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [15:0] cfg_words,
  output logic busy,
  output logic done,
  fifo_drain_pack_if.master bus
);
`ifdef FIFO_DRAIN_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  localparam int CW = 16 + $clog2(PACK);
  localparam int IW = $clog2(PACK);
  localparam int SW = $clog2(SKID_DEPTH);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;
  state_t state, state_nxt;
  logic [15:0] cfg_q;
  logic [CW-1:0] total, issued, wcnt;
  logic [RD_LAT-1:0] sr;
  logic [WIDTH-1:0] skid [SKID_DEPTH];
  logic [SW-1:0] wp, rp;
  logic [SW:0] cnt;
  logic [WIDTH-1:0] lane [PACK-1];
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] head;
  logic [WIDTH*PACK-1:0] word;
  logic push, pop, load, hs;
  assign head = skid[rp];
  assign push = sr[RD_LAT-1];
  assign hs = bus.out_valid && bus.out_ready;
  // the final lane bypasses the lane registers and only pops when the output register can take the word
  assign pop = cnt != 0 && (idx != IW'(PACK-1) || !bus.out_valid || bus.out_ready);
  assign load = pop && idx == IW'(PACK-1);
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb
    case (state)
      IDLE:    state_nxt = !start ? IDLE : cfg_words == 16'd0 ? DONE : DRAIN;
      DRAIN:   state_nxt = issued == total ? FLUSH : DRAIN;
      FLUSH:   state_nxt = hs && bus.out_last ? DONE : FLUSH;
      default: state_nxt = IDLE;
    endcase
  // credit: in-flight pops plus skid occupancy never exceed the skid size
  always_comb begin
    bus.fifo_rinc = state == DRAIN && !bus.fifo_rempty && issued < total
                    && CW'($countones(sr)) + CW'(cnt) < CW'(SKID_DEPTH);
    busy = state == DRAIN || state == FLUSH;
    done = state == DONE;
  end
  always_comb begin
    word = '0;
    for (int i = 0; i < PACK-1; i++) word[(MSB ? PACK-1-i : i)*WIDTH +: WIDTH] = lane[i];
    word[(MSB ? 0 : PACK-1)*WIDTH +: WIDTH] = head;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cfg_q <= '0;
      total <= '0;
      issued <= '0;
      wcnt <= '0;
      sr <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      idx <= '0;
      for (int i = 0; i < PACK-1; i++) lane[i] <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cfg_q <= cfg_words;
        total <= CW'(cfg_words) * CW'(PACK);
        issued <= '0;
        wcnt <= '0;
      end else if (bus.fifo_rinc) issued <= issued + 1'b1;
      sr <= RD_LAT'({sr, bus.fifo_rinc});
      if (push) begin
        skid[wp] <= bus.fifo_rdata;
        wp <= wp == SW'(SKID_DEPTH-1) ? '0 : wp + 1'b1;
      end
      if (pop) begin
        rp <= rp == SW'(SKID_DEPTH-1) ? '0 : rp + 1'b1;
        idx <= idx == IW'(PACK-1) ? '0 : idx + 1'b1;
      end
      cnt <= cnt + (SW+1)'(push) - (SW+1)'(pop);
      for (int i = 0; i < PACK-1; i++) if (pop && idx == IW'(i)) lane[i] <= head;
      if (load) begin
        bus.out_valid <= 1'b1;
        bus.out_data <= word;
        bus.out_last <= wcnt == CW'(cfg_q) - 1'b1;
        wcnt <= wcnt + 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_fifo_drain_pack.sv
// tb_fifo_drain_pack: randomized drains of fifo_drain_pack against a FIFO model and a word-level scoreboard
module tb_fifo_drain_pack;
  localparam int W = 8, P = 4, RL = 2, SD = 4;
`ifdef FIFO_DRAIN_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
  localparam logic [W*P-1:0] WORD0 = 32'h01020304;
`else
  localparam bit MSB = 1'b0;
  localparam logic [W*P-1:0] WORD0 = 32'h04030201;
`endif
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [15:0] cfg_words = '0;
  logic busy, done;
  fifo_drain_pack_if #(.WIDTH(W), .PACK(P)) bus ();
  fifo_drain_pack #(.WIDTH(W), .PACK(P), .RD_LAT(RL), .SKID_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_words(cfg_words),
    .busy(busy), .done(done), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] pipe [RL];
  logic [W*P-1:0] exp_q[$];
  logic [W-1:0] pend_d;
  bit pend_v;
  logic [W*P-1:0] first_word;
  int n_cmp, n_bad, cyc_n, pops, hs_n, last_hs, done_cyc, first_v, ahead_max;
  int empty_pct, ready_pct, stall_at;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input bit st, input bit rs);
    logic [W*P-1:0] w;
    @(posedge clk);
    #1;
    start = st;
    rst = rs;
    for (int i = RL-1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = pend_v ? pend_d : '0;
    pend_v = 1'b0;
    bus.fifo_rdata = pipe[RL-1];
    bus.fifo_rempty = fifo_q.size() == 0 || int'($urandom_range(99)) < empty_pct;
    bus.out_ready = !(cyc_n >= stall_at && cyc_n < stall_at + 20) && int'($urandom_range(99)) < ready_pct;
    @(negedge clk);
    cyc_n++;
    if (bus.fifo_rinc === 1'b1) begin
      chk("rinc_while_empty", bus.fifo_rempty, 0);
      if (!bus.fifo_rempty) begin
        pend_d = fifo_q.pop_front();
        pend_v = 1'b1;
        pops++;
      end
    end
    if (bus.out_valid === 1'b1 && first_v < 0) first_v = cyc_n;
    if (bus.out_valid === 1'b1 && bus.out_ready) begin
      chk("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("word_data", bus.out_data, w);
        chk("word_last", bus.out_last, exp_q.size() == 0);
      end
      if (hs_n == 0) first_word = bus.out_data;
      hs_n++;
      last_hs = cyc_n;
    end
    if (pops - hs_n * P > ahead_max) ahead_max = pops - hs_n * P;
    if (done === 1'b1 && done_cyc < 0) begin
      done_cyc = cyc_n;
      chk("busy_at_done", busy, 0);
    end
  endtask
  task automatic prep(input int cfg);
    logic [W*P-1:0] w;
    exp_q.delete();
    pops = 0;
    hs_n = 0;
    done_cyc = -1;
    first_v = -1;
    last_hs = -1;
    ahead_max = 0;
    for (int j = 0; j < cfg; j++) begin
      w = '0;
      for (int i = 0; i < P; i++) w[(MSB ? P-1-i : i)*W +: W] = fifo_q[j*P+i];
      exp_q.push_back(w);
    end
    cfg_words = 16'(cfg);
  endtask
  task automatic run(input int cfg, input int e, input int r, input bit lat, input int stall_off, input bit poke);
    int s;
    prep(cfg);
    empty_pct = e;
    ready_pct = r;
    cyc(1'b1, 1'b0);
    s = cyc_n;
    stall_at = stall_off > 0 ? s + stall_off : -100;
    for (int n = 0; n < 4000 && done_cyc < 0; n++) begin
      if (poke && n == 10) cfg_words = 16'd7;
      cyc(poke && n == 10, 1'b0);
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("pop_count", pops, cfg * P);
    chk("word_count", hs_n, cfg);
    chk("done_latency", done_cyc - (cfg > 0 ? last_hs : s), 1);
    if (lat) chk("first_valid_latency", first_v - s, P + RL + 2);
    if (stall_off > 0) chk("skid_bound", ahead_max <= SD + 2*P - 1, 1);
    stall_at = -100;
  endtask
  task automatic chk_rst();
    chk("rst_rinc", bus.fifo_rinc, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask
  initial begin
    bus.fifo_rempty = 1'b1;
    bus.out_ready = 1'b0;
    bus.fifo_rdata = '0;
    for (int i = 0; i < RL; i++) pipe[i] = '0;
    stall_at = -100;
    empty_pct = 0;
    ready_pct = 100;
    done_cyc = -1;
    first_v = -1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk_rst();
    cyc(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) fifo_q.push_back(W'(i));
    run(2, 0, 100, 1'b1, 0, 1'b0);
    chk("first_word_const", first_word, WORD0);
    run(0, 0, 100, 1'b0, 0, 1'b0);
    for (int i = 0; i < 300; i++) fifo_q.push_back(W'($urandom));
    run(8, 0, 100, 1'b0, 6, 1'b0);
    run(16, 40, 70, 1'b0, 0, 1'b1);
    prep(8);
    empty_pct = 10;
    ready_pct = 100;
    cyc(1'b1, 1'b0);
    for (int n = 0; n < 8; n++) cyc(1'b0, 1'b0);
    chk("busy_before_rst", busy, 1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk_rst();
    run(3, 20, 80, 1'b0, 0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
